arith_pipe: RTL and testbench

Parametrised, pipelined integer ALU functional unit for the out-of-order core. It is the successor to the single-cycle arith unit. It accepts one issued RV32I/RV64I integer instruction per cycle over a valid/ready handshake and carries the ROB tag through the pipeline. It returns the writeback value to the CDB arbiter after a configurable number of stages, with backpressure and flush support.

---
 rtl/arith_pipe.sv | 184 ++++++++++++++++++
 tb/tb_arith_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_pipe.sv
// Pipelined RV32I/RV64I integer ALU for the out-of-order core.
// Stage 0 decodes and computes; later stages only carry results toward the CDB.
module arith_pipe #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [TAG_W-1:0] issue_tag_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [31:0]      inst_i,
    input  logic [XLEN-1:0]  rs1_value_i,
    input  logic [XLEN-1:0]  rs2_value_i,
    input  logic             flush_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [TAG_W-1:0] wb_tag_o,
    output logic [XLEN-1:0]  wb_value_o,
    output logic             wb_illegal_o
);

    localparam int         SHW         = $clog2(XLEN);
    localparam bit         IS64        = (XLEN == 64);
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_f7Zero;
    logic            w_f7Alt;
    logic            w_immShOk;
    logic [XLEN-1:0] w_immI;
    logic [XLEN-1:0] w_immU;
    logic [XLEN-1:0] w_opB;
    logic [SHW-1:0]  w_shamt;
    logic [31:0]     w_a32;
    logic [31:0]     w_b32;
    logic [4:0]      w_sh5;
    logic [XLEN-1:0] w_result;
    logic            w_illegal;
    logic            w_adv;
    logic            w_unusedBits;

    logic [STAGES-1:0] r_valid;
    logic [TAG_W-1:0]  r_tag     [STAGES];
    logic [XLEN-1:0]   r_value   [STAGES];
    logic              r_illegal [STAGES];

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    assign w_opcode     = inst_i[6:0];
    assign w_funct3     = inst_i[14:12];
    assign w_f7Zero     = (inst_i[31:25] == 7'b0000000);
    assign w_f7Alt      = (inst_i[31:25] == 7'b0100000);
    assign w_immI       = XLEN'($signed(inst_i[31:20]));
    assign w_immU       = XLEN'($signed({inst_i[31:12], 12'b0}));
    assign w_opB        = (w_opcode == OPC_OP || w_opcode == OPC_OP32) ? rs2_value_i : w_immI;
    assign w_shamt      = w_opB[SHW-1:0];
    assign w_sh5        = w_opB[4:0];
    assign w_a32        = rs1_value_i[31:0];
    assign w_b32        = w_opB[31:0];
    assign w_unusedBits = ^inst_i[11:7];

    // inst[25] is the top shamt bit on RV64 but must be zero on RV32; inst[30] picks SRAI.
    assign w_immShOk = (inst_i[31] == 1'b0) && (inst_i[29:26] == 4'b0000) &&
                       (IS64 || (inst_i[25] == 1'b0));

    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_OPIMM, OPC_OP: begin
                if (w_opcode == OPC_OP && !w_f7Zero &&
                    !(w_f7Alt && (w_funct3 == 3'b000 || w_funct3 == 3'b101))) begin
                    w_illegal = 1'b1;
                end else begin
                    case (w_funct3)
                        3'b000: w_result = (w_opcode == OPC_OP && w_f7Alt) ?
                                           rs1_value_i - w_opB : rs1_value_i + w_opB;
                        3'b010: w_result = XLEN'($signed(rs1_value_i) < $signed(w_opB));
                        3'b011: w_result = XLEN'(rs1_value_i < w_opB);
                        3'b100: w_result = rs1_value_i ^ w_opB;
                        3'b110: w_result = rs1_value_i | w_opB;
                        3'b111: w_result = rs1_value_i & w_opB;
                        3'b001: begin
                            if (w_opcode == OPC_OPIMM && !(w_immShOk && !inst_i[30]))
                                w_illegal = 1'b1;
                            else
                                w_result = rs1_value_i << w_shamt;
                        end
                        default: begin
                            if (w_opcode == OPC_OPIMM && !w_immShOk)
                                w_illegal = 1'b1;
                            else if (inst_i[30])
                                w_result = $signed(rs1_value_i) >>> w_shamt;
                            else
                                w_result = rs1_value_i >> w_shamt;
                        end
                    endcase
                end
            end
            OPC_LUI:   w_result = w_immU;
            OPC_AUIPC: w_result = pc_i + w_immU;
            OPC_OPIMM32, OPC_OP32: begin
                if (!IS64) begin
                    w_illegal = 1'b1;
                end else begin
                    case (w_funct3)
                        3'b000: begin
                            if (w_opcode == OPC_OPIMM32 || w_f7Zero)
                                w_result = sext32(w_a32 + w_b32);
                            else if (w_f7Alt)
                                w_result = sext32(w_a32 - w_b32);
                            else
                                w_illegal = 1'b1;
                        end
                        3'b001: begin
                            if (w_f7Zero)
                                w_result = sext32(w_a32 << w_sh5);
                            else
                                w_illegal = 1'b1;
                        end
                        3'b101: begin
                            if (w_f7Zero)
                                w_result = sext32(w_a32 >> w_sh5);
                            else if (w_f7Alt)
                                w_result = sext32($signed(w_a32) >>> w_sh5);
                            else
                                w_illegal = 1'b1;
                        end
                        default: w_illegal = 1'b1;
                    endcase
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_adv         = !wb_valid_o || wb_ready_i;
    assign issue_ready_o = w_adv;

    // Global stall: every stage shifts together or holds together; flush overrides both.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_tag[i]     <= '0;
                r_value[i]   <= '0;
                r_illegal[i] <= 1'b0;
            end
        end else begin
            if (w_adv) begin
                r_valid[0]   <= issue_valid_i;
                r_tag[0]     <= issue_tag_i;
                r_value[0]   <= w_result;
                r_illegal[0] <= w_illegal;
                for (int i = 1; i < STAGES; i++) begin
                    r_valid[i]   <= r_valid[i-1];
                    r_tag[i]     <= r_tag[i-1];
                    r_value[i]   <= r_value[i-1];
                    r_illegal[i] <= r_illegal[i-1];
                end
            end
            if (flush_i) begin
                r_valid <= '0;
            end
        end
    end

    assign wb_valid_o   = r_valid[STAGES-1];
    assign wb_tag_o     = r_tag[STAGES-1];
    assign wb_value_o   = r_value[STAGES-1];
    assign wb_illegal_o = r_illegal[STAGES-1];

endmodule

// File: tb/tb_arith_pipe.sv
// Scoreboard bench for arith_pipe: a 32-bit instance for the main traffic and
// a 64-bit instance for the W-form and wide-shift cases.
module tb_arith_pipe;

    localparam int TAG_W  = 6;
    localparam int STAGES = 2;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] value;
        logic        illegal;
    } expEntry_t;

    logic        clk = 1'b0;
    logic        reset, issueValid, flush, wbReady;
    logic [5:0]  issueTag;
    logic [31:0] pc, inst, rs1, rs2;
    logic        issueReady, wbValid, wbIllegal;
    logic [5:0]  wbTag;
    logic [31:0] wbValue;

    logic        reset64, issueValid64, flush64, wbReady64;
    logic [5:0]  issueTag64;
    logic [63:0] pc64, rs1Val64, rs2Val64;
    logic [31:0] inst64;
    logic        issueReady64, wbValid64, wbIllegal64;
    logic [5:0]  wbTag64;
    logic [63:0] wbValue64;

    expEntry_t   sbQ[$];
    expEntry_t   popped, pushEntry;
    logic [31:0] expValue;
    logic        expIllegal;
    int          nVectors = 0;
    int          nMiscompares = 0;
    bit          monOn = 1'b0;
    bit          randReady = 1'b0;

    always #5 clk = ~clk;

    arith_pipe #(.XLEN(32), .TAG_W(TAG_W), .STAGES(STAGES)) dut (
        .clk_i(clk), .reset_i(reset), .issue_valid_i(issueValid), .issue_ready_o(issueReady),
        .issue_tag_i(issueTag), .pc_i(pc), .inst_i(inst), .rs1_value_i(rs1), .rs2_value_i(rs2),
        .flush_i(flush), .wb_valid_o(wbValid), .wb_ready_i(wbReady), .wb_tag_o(wbTag),
        .wb_value_o(wbValue), .wb_illegal_o(wbIllegal)
    );

    arith_pipe #(.XLEN(64), .TAG_W(TAG_W), .STAGES(STAGES)) dut64 (
        .clk_i(clk), .reset_i(reset64), .issue_valid_i(issueValid64), .issue_ready_o(issueReady64),
        .issue_tag_i(issueTag64), .pc_i(pc64), .inst_i(inst64), .rs1_value_i(rs1Val64),
        .rs2_value_i(rs2Val64), .flush_i(flush64), .wb_valid_o(wbValid64), .wb_ready_i(wbReady64),
        .wb_tag_o(wbTag64), .wb_value_o(wbValue64), .wb_illegal_o(wbIllegal64)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pcv, input logic [5:0] tag,
                                 input logic [31:0] ev, input logic ei);
        inst = instr; rs1 = a; rs2 = b; pc = pcv; issueTag = tag;
        expValue = ev; expIllegal = ei; issueValid = 1'b1;
    endtask

    task automatic issueOne(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pcv, input logic [5:0] tag,
                            input logic [31:0] ev, input logic ei);
        int budget = 0;
        applyStimulus(instr, a, b, pcv, tag, ev, ei);
        @(negedge clk);
        while (!issueReady && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!issueReady) checkOutput("issue_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        issueValid = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while (sbQ.size() != 0 && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        if (sbQ.size() != 0) begin
            checkOutput("drain_timeout", 64'(sbQ.size()), 64'd0);
            sbQ.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic run64(input logic [31:0] instr, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] tag, input logic [63:0] ev);
        int budget = 0;
        inst64 = instr; rs1Val64 = a; rs2Val64 = b; issueTag64 = tag; issueValid64 = 1'b1;
        @(negedge clk);
        checkOutput("w64_ready", 64'(issueReady64), 64'd1);
        @(posedge clk); #1;
        issueValid64 = 1'b0;
        while (!wbValid64 && budget < 10) begin
            @(posedge clk); #1;
            budget++;
        end
        checkOutput("w64_valid", 64'(wbValid64), 64'd1);
        checkOutput("w64_value", wbValue64, ev);
        checkOutput("w64_tag", 64'(wbTag64), 64'(tag));
        checkOutput("w64_illegal", 64'(wbIllegal64), 64'd0);
        @(posedge clk); #1;
    endtask

    // Pop before push: an instruction accepted this cycle cannot also be retiring.
    always @(negedge clk) begin
        if (monOn) begin
            if (reset) begin
                sbQ.delete();
            end else begin
                if (wbValid && wbReady) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("spurious_wb", 64'd1, 64'd0);
                    end else begin
                        popped = sbQ.pop_front();
                        checkOutput("wb_tag", 64'(wbTag), 64'(popped.tag));
                        checkOutput("wb_value", 64'(wbValue), 64'(popped.value));
                        checkOutput("wb_illegal", 64'(wbIllegal), 64'(popped.illegal));
                    end
                end
                if (flush) begin
                    sbQ.delete();
                end else if (issueValid && issueReady) begin
                    pushEntry.tag     = issueTag;
                    pushEntry.value   = expValue;
                    pushEntry.illegal = expIllegal;
                    sbQ.push_back(pushEntry);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (randReady) begin
            #1;
            wbReady = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: still running at %0t, required to finish before 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a, b, ev;
        logic [6:0]  f7;
        logic [2:0]  f3;

        reset = 1'b1; issueValid = 1'b0; flush = 1'b0; wbReady = 1'b1;
        issueTag = '0; pc = '0; inst = '0; rs1 = '0; rs2 = '0; expValue = '0; expIllegal = 1'b0;
        reset64 = 1'b1; issueValid64 = 1'b0; flush64 = 1'b0; wbReady64 = 1'b1;
        issueTag64 = '0; pc64 = '0; inst64 = '0; rs1Val64 = '0; rs2Val64 = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; reset64 = 1'b0;
        monOn = 1'b1;
        @(negedge clk);
        checkOutput("rst_wb_valid", 64'(wbValid), 64'd0);
        checkOutput("rst_wb_tag", 64'(wbTag), 64'd0);
        checkOutput("rst_wb_value", 64'(wbValue), 64'd0);
        checkOutput("rst_wb_illegal", 64'(wbIllegal), 64'd0);
        checkOutput("rst_issue_ready", 64'(issueReady), 64'd1);
        @(posedge clk); #1;

        $display("[TB] latency and back-to-back issue");
        applyStimulus(32'h00518093, 32'd2, 32'd0, 32'd0, 6'd3, 32'd7, 1'b0);
        @(posedge clk); #1;
        checkOutput("lat_early_valid", 64'(wbValid), 64'd0);
        applyStimulus(32'h00209113, 32'd5, 32'd0, 32'd0, 6'd4, 32'h14, 1'b0);
        @(posedge clk); #1;
        issueValid = 1'b0;
        checkOutput("lat_valid", 64'(wbValid), 64'd1);
        checkOutput("lat_tag", 64'(wbTag), 64'd3);
        @(posedge clk); #1;
        checkOutput("b2b_valid", 64'(wbValid), 64'd1);
        checkOutput("b2b_tag", 64'(wbTag), 64'd4);
        drain();

        $display("[TB] directed ALU vectors");
        issueOne(32'h40208133, 32'h10,       32'd5,        32'd0, 6'd10, 32'hB,        1'b0);
        issueOne(32'h4020D133, 32'h80000000, 32'd4,        32'd0, 6'd11, 32'hF8000000, 1'b0);
        issueOne(32'h0020D133, 32'h80000000, 32'd4,        32'd0, 6'd12, 32'h08000000, 1'b0);
        issueOne(32'h0020B133, 32'd1,        32'hFFFFFFFF, 32'd0, 6'd13, 32'd1,        1'b0);
        issueOne(32'h0020A133, 32'd1,        32'hFFFFFFFF, 32'd0, 6'd14, 32'd0,        1'b0);
        issueOne(32'h4040D113, 32'h80000000, 32'd0,        32'd0, 6'd15, 32'hF8000000, 1'b0);
        issueOne(32'hFFF0C113, 32'h0F0F0F0F, 32'd0,        32'd0, 6'd16, 32'hF0F0F0F0, 1'b0);
        issueOne(32'hFFF0A113, 32'h80000000, 32'd0,        32'd0, 6'd17, 32'd1,        1'b0);
        issueOne(32'hFFF0B113, 32'd5,        32'd0,        32'd0, 6'd18, 32'd1,        1'b0);
        issueOne(32'h0FF0F113, 32'h12345678, 32'd0,        32'd0, 6'd19, 32'h78,       1'b0);
        issueOne(32'h8000E113, 32'd1,        32'd0,        32'd0, 6'd20, 32'hFFFFF801, 1'b0);
        issueOne(32'h0000007F, 32'h55,       32'h66,       32'd0, 6'd9,  32'd0,        1'b1);
        issueOne(32'h00001097, 32'd0,        32'd0,        32'd8, 6'd21, 32'h1008,     1'b0);
        issueOne(32'hFFFFF0B7, 32'd0,        32'd0,        32'd0, 6'd22, 32'hFFFFF000, 1'b0);
        issueOne(32'h02208133, 32'd3,        32'd4,        32'd0, 6'd23, 32'd0,        1'b1);
        issueOne(32'h0020813B, 32'd3,        32'd4,        32'd0, 6'd24, 32'd0,        1'b1);
        issueOne(32'h02009093, 32'd1,        32'd0,        32'd0, 6'd25, 32'd0,        1'b1);
        issueOne(32'h00209133, 32'd3,        32'h21,       32'd0, 6'd26, 32'd6,        1'b0);
        issueOne(32'h00208133, 32'hFFFFFFFF, 32'd2,        32'd0, 6'd27, 32'd1,        1'b0);
        drain();

        $display("[TB] backpressure");
        wbReady = 1'b0;
        issueOne(32'h00518093, 32'd2,  32'd0, 32'd0, 6'd40, 32'd7,        1'b0);
        issueOne(32'h40208133, 32'h10, 32'd5, 32'd0, 6'd41, 32'hB,        1'b0);
        applyStimulus(32'hFFFFF0B7, 32'd0, 32'd0, 32'd0, 6'd42, 32'hFFFFF000, 1'b0);
        #1;
        checkOutput("bp_ready_low", 64'(issueReady), 64'd0);
        checkOutput("bp_valid", 64'(wbValid), 64'd1);
        checkOutput("bp_tag", 64'(wbTag), 64'd40);
        checkOutput("bp_value", 64'(wbValue), 64'd7);
        repeat (2) begin
            @(posedge clk); #2;
            checkOutput("bp_hold_ready", 64'(issueReady), 64'd0);
            checkOutput("bp_hold_tag", 64'(wbTag), 64'd40);
            checkOutput("bp_hold_value", 64'(wbValue), 64'd7);
            checkOutput("bp_hold_illegal", 64'(wbIllegal), 64'd0);
        end
        wbReady = 1'b1;
        @(posedge clk); #1;
        issueValid = 1'b0;
        checkOutput("bp_next_valid", 64'(wbValid), 64'd1);
        checkOutput("bp_next_tag", 64'(wbTag), 64'd41);
        drain();

        $display("[TB] flush with instructions in flight");
        issueOne(32'h00518093, 32'd2, 32'd0, 32'd0, 6'd50, 32'd7,  1'b0);
        issueOne(32'h00209113, 32'd5, 32'd0, 32'd0, 6'd51, 32'h14, 1'b0);
        checkOutput("flush_pre_valid", 64'(wbValid), 64'd1);
        wbReady = 1'b0;
        flush = 1'b1;
        applyStimulus(32'hFFFFF0B7, 32'd0, 32'd0, 32'd0, 6'd52, 32'hFFFFF000, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; issueValid = 1'b0; wbReady = 1'b1;
        checkOutput("flush_valid_0", 64'(wbValid), 64'd0);
        @(posedge clk); #1;
        checkOutput("flush_valid_1", 64'(wbValid), 64'd0);
        flush = 1'b1;
        applyStimulus(32'h00518093, 32'd2, 32'd0, 32'd0, 6'd53, 32'd7, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; issueValid = 1'b0;
        @(posedge clk); #1;
        checkOutput("flush_drop_0", 64'(wbValid), 64'd0);
        @(posedge clk); #1;
        checkOutput("flush_drop_1", 64'(wbValid), 64'd0);
        issueOne(32'h00518093, 32'd9, 32'd0, 32'd0, 6'd54, 32'd14, 1'b0);
        drain();

        $display("[TB] random register ops with random backpressure");
        randReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 6))
                0:       begin f7 = 7'h00; f3 = 3'd0; ev = a + b; end
                1:       begin f7 = 7'h20; f3 = 3'd0; ev = a - b; end
                2:       begin f7 = 7'h00; f3 = 3'd4; ev = a ^ b; end
                3:       begin f7 = 7'h00; f3 = 3'd6; ev = a | b; end
                4:       begin f7 = 7'h00; f3 = 3'd7; ev = a & b; end
                5:       begin f7 = 7'h00; f3 = 3'd1; ev = a << b[4:0]; end
                default: begin f7 = 7'h00; f3 = 3'd3; ev = (a < b) ? 32'd1 : 32'd0; end
            endcase
            issueOne({f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011}, a, b, 32'd0, 6'(i), ev, 1'b0);
        end
        randReady = 1'b0;
        @(posedge clk); #2;
        wbReady = 1'b1;
        drain();

        $display("[TB] reset mid-stream");
        wbReady = 1'b0;
        issueOne(32'hFFFFF0B7, 32'd0, 32'd0, 32'd0, 6'd60, 32'hFFFFF000, 1'b0);
        issueOne(32'h0000007F, 32'd0, 32'd0, 32'd0, 6'd61, 32'd0,        1'b1);
        checkOutput("rst_pre_valid", 64'(wbValid), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_mid_valid", 64'(wbValid), 64'd0);
        checkOutput("rst_mid_tag", 64'(wbTag), 64'd0);
        checkOutput("rst_mid_value", 64'(wbValue), 64'd0);
        checkOutput("rst_mid_illegal", 64'(wbIllegal), 64'd0);
        reset = 1'b0; wbReady = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_ready", 64'(issueReady), 64'd1);
        @(posedge clk); #1;
        checkOutput("rst_mid_quiet", 64'(wbValid), 64'd0);
        issueOne(32'h00001097, 32'd0, 32'd0, 32'h100, 6'd62, 32'h1100, 1'b0);
        drain();

        $display("[TB] XLEN=64 instance");
        run64(32'h0020813B, 64'h7FFFFFFF,         64'd1,  6'd1, 64'hFFFFFFFF80000000);
        run64(32'h4020813B, 64'd0,                64'd1,  6'd2, 64'hFFFFFFFFFFFFFFFF);
        run64(32'h4040D11B, 64'h0000000180000000, 64'd0,  6'd3, 64'hFFFFFFFFF8000000);
        run64(32'h02009093, 64'd1,                64'd0,  6'd4, 64'h0000000100000000);
        run64(32'h00208133, 64'hFFFFFFFFFFFFFFFF, 64'd2,  6'd5, 64'd1);
        run64(32'h0020913B, 64'h0000000100000001, 64'h3F, 6'd6, 64'hFFFFFFFF80000000);
        wbReady64 = 1'b0;
        inst64 = 32'h0020813B; rs1Val64 = 64'h7FFFFFFF; rs2Val64 = 64'd1;
        issueTag64 = 6'd7; issueValid64 = 1'b1;
        @(posedge clk); #1;
        issueValid64 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("w64_rst_pre_valid", 64'(wbValid64), 64'd1);
        reset64 = 1'b1;
        @(posedge clk); #1;
        checkOutput("w64_rst_valid", 64'(wbValid64), 64'd0);
        checkOutput("w64_rst_tag", 64'(wbTag64), 64'd0);
        checkOutput("w64_rst_value", wbValue64, 64'd0);
        checkOutput("w64_rst_illegal", 64'(wbIllegal64), 64'd0);
        reset64 = 1'b0; wbReady64 = 1'b1;

        checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
